// File: rtl/pci_arb_pkg.sv
// ---------------------------------------------------------------------------
// pci_arb_pkg
// Shared types and helpers for the AmigaPCI bus arbiter.
//   arb_state_e : arbiter FSM states (ARB, GRANT, DEAD)
//   MAX_REQ     : widest requester vector the helper function handles
//   MAX_IDW     : index width for MAX_REQ requesters
//   rr_pick_t   : result of a round-robin search (found flag + index)
//   next_rr()   : round-robin search starting one past ptr, wrapping at num
// The per-instance index width (IDW = $clog2(NUM_REQ)) is derived inside each
// module from its own NUM_REQ parameter, since a package cannot see it.
// ---------------------------------------------------------------------------
package pci_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    GRANT = 2'd1,
    DEAD  = 2'd2
  } arb_state_e;

  localparam int MAX_REQ = 8;
  localparam int MAX_IDW = $clog2(MAX_REQ);

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // Search req_vec (active-high) from ptr+1 upward, wrapping at num, and
  // return the first requesting index. ptr must be below num, so ptr+i never
  // exceeds 2*num-1 and a single subtraction performs the wrap.
  function automatic rr_pick_t next_rr(input logic [MAX_REQ-1:0] req_vec,
                                       input logic [MAX_IDW-1:0] ptr,
                                       input int                 num);
    rr_pick_t   r;
    logic [3:0] cand;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(num)) cand = cand - 4'(num);
      if ((i <= num) && !r.found && req_vec[cand[MAX_IDW-1:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[MAX_IDW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pci_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// pci_arb_rr_pick
// Combinational round-robin picker. Usable by any requester/grant arbiter.
// Ports:
//   req    in  NUM_REQ  active-high request vector
//   ptr    in  IDW      index of the last winner; search starts at ptr+1
//   winner out IDW      first requesting index in round-robin order
//   found  out 1        high when any request bit is set
// ---------------------------------------------------------------------------
module pci_arb_rr_pick
  import pci_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     winner,
  output logic               found
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_IDW-1:0] ptr_ext;
  rr_pick_t           pick;

  always_comb begin
    req_ext = MAX_REQ'(req);
    ptr_ext = MAX_IDW'(ptr);
    pick    = next_rr(req_ext, ptr_ext, NUM_REQ);
    winner  = IDW'(pick.idx);
    found   = pick.found;
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// ---------------------------------------------------------------------------
// pci_bus_arbiter
// Central PCI bus arbiter: round-robin grants, bus parking on PARK_ID and an
// idle-grant timeout. All outputs are registered.
// Ports:
//   PCICLK    in  1        clock
//   RESET     in  1        synchronous, active-high reset
//   nREQ      in  NUM_REQ  active-low requests (already in PCICLK domain)
//   nFRAME    in  1        PCI FRAME#, active low
//   nIRDY     in  1        PCI IRDY#, active low
//   nGNT      out NUM_REQ  active-low one-hot grants
//   OWNER     out IDW      current / last grantee
//   GNT_VALID out 1        high while any grant is driven
//   dbg_state out 2        current FSM state, for observation only
// Build option: define ARB_HOST_PRIORITY_EN to make requester 0 (host bridge)
// win every arbitration it takes part in.
//
// Handshake: an agent asserts nREQ[i] low and holds it until it sees
// nGNT[i] low with the bus idle; nGNT is withdrawn when the owner releases
// REQ#, when another agent is waiting once the owner has started a
// transaction, or after IDLE_TIMEOUT idle clocks while another agent waits.
// Every grant is separated from the next by one DEAD and one ARB clock.
// ---------------------------------------------------------------------------
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int PARK_ID      = 0,
  parameter  int IDLE_TIMEOUT = 16,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic               PCICLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] nREQ,
  input  logic               nFRAME,
  input  logic               nIRDY,
  output logic [NUM_REQ-1:0] nGNT,
  output logic [IDW-1:0]     OWNER,
  output logic               GNT_VALID,
  output arb_state_e         dbg_state
);

  localparam logic [7:0]     IDLE_TO  = 8'(IDLE_TIMEOUT);
  localparam logic [IDW-1:0] PARK_IDX = IDW'(PARK_ID);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               frame_seen_q, frame_seen_d;
  logic [NUM_REQ-1:0] ngnt_q, ngnt_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic               gnt_valid_q, gnt_valid_d;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] owner_mask;
  logic               bus_idle;
  logic               any_req;
  logic               other_pending;
  logic               park_hold;
  logic               idle_count_en;
  logic [7:0]         cnt_next;
  logic               exit_grant;
  logic [IDW-1:0]     pick_winner;
  logic               pick_found;
  logic [IDW-1:0]     arb_winner;

  pci_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .winner (pick_winner),
    .found  (pick_found)
  );

  // Grant-tenure bookkeeping, evaluated every clock but only used in GRANT.
  always_comb begin
    req           = ~nREQ;
    bus_idle      = nFRAME & nIRDY;
    owner_mask    = NUM_REQ'(1) << owner_q;
    any_req       = |req;
    other_pending = |(req & ~owner_mask);
    // A parked owner with nobody asking keeps the bus without a timeout.
    park_hold     = (owner_q == PARK_IDX) && !any_req;
    idle_count_en = bus_idle && !frame_seen_q && !park_hold;
    if (!idle_count_en)          cnt_next = 8'd0;
    else if (cnt_q >= IDLE_TO)   cnt_next = IDLE_TO;
    else                         cnt_next = cnt_q + 8'd1;
    exit_grant = (!req[owner_q] && !park_hold)
              || (frame_seen_q && other_pending)
              || ((cnt_next == IDLE_TO) && other_pending);
  end

  always_comb begin
`ifdef ARB_HOST_PRIORITY_EN
    if (req[0])          arb_winner = '0;
    else if (pick_found) arb_winner = pick_winner;
    else                 arb_winner = PARK_IDX;
`else
    if (pick_found)      arb_winner = pick_winner;
    else                 arb_winner = PARK_IDX;
`endif
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    frame_seen_d = frame_seen_q;
    ngnt_d       = ngnt_q;
    owner_d      = owner_q;
    gnt_valid_d  = gnt_valid_q;
    case (state_q)
      ARB: begin
        ngnt_d       = ~(NUM_REQ'(1) << arb_winner);
        owner_d      = arb_winner;
        gnt_valid_d  = 1'b1;
        cnt_d        = 8'd0;
        frame_seen_d = 1'b0;
        state_d      = GRANT;
      end
      GRANT: begin
        frame_seen_d = frame_seen_q | ~nFRAME;
        cnt_d        = cnt_next;
        if (exit_grant) begin
          ngnt_d       = '1;
          gnt_valid_d  = 1'b0;
          rr_ptr_d     = owner_q;
          cnt_d        = 8'd0;
          frame_seen_d = 1'b0;
          state_d      = DEAD;
        end
      end
      DEAD: begin
        state_d = ARB;
      end
      default: begin
        ngnt_d      = '1;
        gnt_valid_d = 1'b0;
        state_d     = DEAD;
      end
    endcase
  end

  always_ff @(posedge PCICLK) begin
    if (RESET) begin
      state_q      <= DEAD;
      rr_ptr_q     <= PARK_IDX;
      cnt_q        <= 8'd0;
      frame_seen_q <= 1'b0;
      ngnt_q       <= '1;
      owner_q      <= PARK_IDX;
      gnt_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      frame_seen_q <= frame_seen_d;
      ngnt_q       <= ngnt_d;
      owner_q      <= owner_d;
      gnt_valid_q  <= gnt_valid_d;
    end
  end

  assign nGNT      = ngnt_q;
  assign OWNER     = owner_q;
  assign GNT_VALID = gnt_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pci_bus_arbiter
// Bench for pci_bus_arbiter (NUM_REQ=4, PARK_ID=0, IDLE_TIMEOUT=16).
// A tenure-level reference model (granted / gap clocks / owner / pointer)
// predicts nGNT, OWNER and GNT_VALID after every clock; directed scenarios
// add literal expectations for the key timing cases.
// ---------------------------------------------------------------------------
module tb_pci_bus_arbiter;
  import pci_arb_pkg::*;

  localparam int N    = 4;
  localparam int PARK = 0;
  localparam int TO   = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] nreq;
  logic         nframe;
  logic         nirdy;
  logic [N-1:0] nGNT;
  logic [1:0]   OWNER;
  logic         GNT_VALID;
  arb_state_e   dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pci_bus_arbiter #(.NUM_REQ(N), .PARK_ID(PARK), .IDLE_TIMEOUT(TO)) dut (
    .PCICLK    (clk),
    .RESET     (rst),
    .nREQ      (nreq),
    .nFRAME    (nframe),
    .nIRDY     (nirdy),
    .nGNT      (nGNT),
    .OWNER     (OWNER),
    .GNT_VALID (GNT_VALID),
    .dbg_state (dbg_state)
  );

  // Reference model state: a tenure is either running (m_granted) or the
  // bus is in its gap, with m_wait gap clocks left before the deciding clock.
  bit           m_granted;
  int           m_wait;
  int           m_owner;
  int           m_ptr;
  int           m_idle;
  bit           m_seen;
  logic [N-1:0] prev_ngnt = '1;

  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
`ifdef ARB_HOST_PRIORITY_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return PARK;
  endfunction

  task automatic model_edge();
    logic [N-1:0] r;
    bit any, others, quiet, leave;
    r = ~nreq;
    if (rst) begin
      m_granted = 0; m_wait = 1; m_owner = PARK; m_ptr = PARK;
      m_idle = 0; m_seen = 0;
    end else if (!m_granted) begin
      if (m_wait > 0) m_wait--;
      else begin
        m_owner = model_pick(r, m_ptr);
        m_granted = 1; m_seen = 0; m_idle = 0;
      end
    end else begin
      any = |r;
      others = 0;
      for (int i = 0; i < N; i++) if (i != m_owner && r[i]) others = 1;
      quiet = (m_owner == PARK) && !any;
      if (nframe && nirdy && !m_seen && !quiet) m_idle = (m_idle < TO) ? m_idle + 1 : TO;
      else m_idle = 0;
      leave = (!r[m_owner] && !quiet) || (m_seen && others) || (m_idle == TO && others);
      m_seen = m_seen || !nframe;
      if (leave) begin
        m_granted = 0; m_wait = 1; m_ptr = m_owner; m_idle = 0; m_seen = 0;
      end
    end
  endtask

  // One clock: advance model with the inputs the DUT samples, then check.
  task automatic cycle();
    logic [N-1:0] exp_ngnt;
    @(posedge clk);
    model_edge();
    #1;
    exp_ngnt = m_granted ? ~(N'(1) << m_owner) : '1;
    total++;
    if (nGNT !== exp_ngnt) begin
      bad++; $display("FAIL model_ngnt t=%0t got=%b exp=%b", $time, nGNT, exp_ngnt);
    end
    total++;
    if (OWNER !== 2'(m_owner)) begin
      bad++; $display("FAIL model_owner t=%0t got=%0d exp=%0d", $time, OWNER, m_owner);
    end
    total++;
    if (GNT_VALID !== m_granted) begin
      bad++; $display("FAIL model_valid t=%0t got=%b exp=%b", $time, GNT_VALID, m_granted);
    end
    total++;
    if (prev_ngnt != '1 && nGNT != '1 && nGNT !== prev_ngnt) begin
      bad++; $display("FAIL direct_handoff t=%0t got=%b prev=%b exp=gap", $time, nGNT, prev_ngnt);
    end
    prev_ngnt = nGNT;
  endtask

  task automatic wait_grant(input string name, input int limit, output int n);
    n = 0;
    while (!GNT_VALID && n < limit) begin cycle(); n++; end
    if (!GNT_VALID) begin
      total++; bad++; $display("FAIL %s_timeout got=no_grant exp=grant_within_%0d", name, limit);
    end
  endtask

  task automatic test_reset();
    rst = 1; nreq = '1; nframe = 1; nirdy = 1;
    repeat (3) cycle();
    total++;
    if (nGNT !== 4'b1111 || OWNER !== 2'd0 || GNT_VALID !== 1'b0) begin
      bad++; $display("FAIL reset_state got=%b/%0d/%b exp=1111/0/0", nGNT, OWNER, GNT_VALID);
    end
    rst = 0;
    cycle(); cycle();
    total++;
    if (nGNT !== 4'b1110 || OWNER !== 2'd0) begin
      bad++; $display("FAIL park_grant got=%b/%0d exp=1110/0", nGNT, OWNER);
    end
    repeat (25) cycle();
    total++;
    if (nGNT !== 4'b1110) begin
      bad++; $display("FAIL park_hold got=%b exp=1110", nGNT);
    end
  endtask

  task automatic test_park_to_req();
    int highs = 0;
    int n = 0;
    nreq = 4'b1011;
    while (nGNT !== 4'b1011 && n < 10) begin
      cycle(); n++;
      if (nGNT === 4'b1111) highs++;
    end
    total++;
    if (nGNT !== 4'b1011 || OWNER !== 2'd2) begin
      bad++; $display("FAIL park_to_req got=%b/%0d exp=1011/2", nGNT, OWNER);
    end
    total++;
    if (highs != 2) begin
      bad++; $display("FAIL park_gap got=%0d exp=2", highs);
    end
    nreq = '1;
    repeat (6) cycle();
  endtask

  task automatic test_round_robin();
    int   order[$];
    int   exp_order[5] = '{1, 2, 3, 0, 1};
    logic last_valid = 0;
    rst = 1; nreq = '0; nframe = 1; nirdy = 1;
    cycle();
    rst = 0;
    for (int k = 0; k < 100 && order.size() < 5; k++) begin
      cycle();
      nframe = 1;
      if (GNT_VALID && !last_valid) begin
        order.push_back(int'(OWNER));
        nframe = 0;
      end
      last_valid = GNT_VALID;
    end
    nframe = 1;
    total++;
    if (order.size() != 5) begin
      bad++; $display("FAIL rr_count got=%0d exp=5", order.size());
    end
    for (int i = 0; i < order.size() && i < 5; i++) begin
      total++;
      if (order[i] != exp_order[i]) begin
        bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    rst = 1; nreq = 4'b0111; nframe = 1; nirdy = 1;
    cycle();
    rst = 0;
    wait_grant("to_first", 10, n);
    total++;
    if (OWNER !== 2'd3) begin
      bad++; $display("FAIL to_owner got=%0d exp=3", OWNER);
    end
    nreq = 4'b0101;
    n = 0;
    while (GNT_VALID && n < 40) begin cycle(); n++; end
    total++;
    if (n != TO) begin
      bad++; $display("FAIL to_withdraw got=%0d exp=%0d", n, TO);
    end
    wait_grant("to_second", 10, n);
    total++;
    if (n != 2 || OWNER !== 2'd1) begin
      bad++; $display("FAIL to_regrant got=%0d/%0d exp=2/1", n, OWNER);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1; nreq = 4'b1011; nframe = 1; nirdy = 1;
    cycle();
    rst = 0;
    wait_grant("rm", 10, n);
    nframe = 0; nirdy = 0;
    repeat (3) cycle();
    total++;
    if (nGNT !== 4'b1011) begin
      bad++; $display("FAIL rm_burst got=%b exp=1011", nGNT);
    end
    rst = 1;
    cycle();
    total++;
    if (nGNT !== 4'b1111 || OWNER !== 2'd0 || GNT_VALID !== 1'b0) begin
      bad++; $display("FAIL rm_reset got=%b/%0d/%b exp=1111/0/0", nGNT, OWNER, GNT_VALID);
    end
    rst = 0; nframe = 1; nirdy = 1; nreq = '1;
    repeat (4) cycle();
  endtask

  // Owner in a burst while requester 0 (and others) wait.
  task automatic test_host_priority();
    int n;
    int exp_w;
    rst = 1; nreq = 4'b0111; nframe = 1; nirdy = 1;
    cycle();
    rst = 0;
    wait_grant("hp_a", 10, n);
    nframe = 0;
    cycle();
    nreq = 4'b0110;
    cycle();
    total++;
    if (nGNT !== 4'b1111) begin
      bad++; $display("FAIL hp_preempt got=%b exp=1111", nGNT);
    end
    nframe = 1;
    cycle(); cycle();
    total++;
    if (nGNT !== 4'b1110) begin
      bad++; $display("FAIL hp_ptr3 got=%b exp=1110", nGNT);
    end
    rst = 1; nreq = 4'b1101;
    cycle();
    rst = 0;
    wait_grant("hp_b", 10, n);
    nframe = 0;
    cycle();
    nreq = 4'b0100;
    cycle(); nframe = 1;
    cycle(); cycle();
`ifdef ARB_HOST_PRIORITY_EN
    exp_w = 0;
`else
    exp_w = 3;
`endif
    total++;
    if (OWNER !== 2'(exp_w) || !GNT_VALID) begin
      bad++; $display("FAIL hp_ptr1 got=%0d/%b exp=%0d/1", OWNER, GNT_VALID, exp_w);
    end
    nreq = '1;
    repeat (4) cycle();
  endtask

  task automatic test_random();
    rst = 1; cycle(); rst = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) nreq = N'($urandom_range(0, 15));
      nframe = ($urandom_range(0, 5) != 0);
      nirdy  = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 0; nframe = 1; nirdy = 1; nreq = '1;
    repeat (4) cycle();
  endtask

  initial begin
    rst = 1; nreq = '1; nframe = 1; nirdy = 1;
    test_reset();
    test_park_to_req();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_host_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
